syscall_console: RTL and testbench

- Downstream consumer of the pipeline's syscall outputs (funct = $v0 value, param1 = $a0 value).
- Queues accepted syscalls in a small FIFO and serialises print requests into an ASCII byte stream on a valid/ready console port.
- Raises a sticky halt on exit.
- Back-pressures the pipeline's hazard logic through stall_req when the queue is full.

---
 rtl/syscall_pkg.sv | 48 ++++
 rtl/syscall_fifo.sv | 66 ++++++
 rtl/syscall_console.sv | 155 +++++++++++++++
 tb/tb_syscall_console.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// ============================================================================
//  Module   : syscall_pkg
//  Brief    : Shared constants, command/state encodings and the hex-digit
//             helper for the syscall console.
//             SYSCALL_NEWLINE_EN adds the ST_NL state to the FSM encoding.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package syscall_pkg;

    // Service codes as they arrive in $v0
    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

    // Compact command stored alongside the parameter in each FIFO entry
    typedef enum logic [1:0] {
        CMD_CHAR = 2'd0,
        CMD_INT  = 2'd1,
        CMD_EXIT = 2'd2
    } cmd_t;

    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_A_LOWER = 8'h61;
    localparam logic [7:0] ASCII_NL      = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHAR = 3'd1,
        ST_HEX  = 3'd2,
        ST_HALT = 3'd3
`ifdef SYSCALL_NEWLINE_EN
        , ST_NL = 3'd4
`endif
    } state_t;

    // Lowercase ASCII hex digit for one nibble
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_0 + {4'd0, nib};
        else
            return ASCII_A_LOWER + {4'd0, nib - 4'd10};
    endfunction

endpackage

`default_nettype wire

// File: rtl/syscall_fifo.sv
// ============================================================================
//  Module   : syscall_fifo
//  Brief    : Synchronous DEPTH x WIDTH FIFO with occupancy count. Pushes
//             while full and pops while empty are ignored.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module syscall_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 34
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/syscall_console.sv
// ============================================================================
//  Module   : syscall_console
//  Brief    : Queues PRINT_INT / PRINT_CHAR / EXIT syscalls and serialises
//             them onto a valid/ready ASCII byte port; sticky halt and
//             bad-syscall flags; stall_req back-pressure when full.
//             Define SYSCALL_NEWLINE_EN to follow every PRINT_INT with 0x0A.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module syscall_console
    import syscall_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             syscall_valid,
    input  logic [31:0]      syscall_funct,
    input  logic [31:0]      syscall_param1,
    output logic             stall_req,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             halted,
    output logic             bad_syscall,
    output logic [PTR_W:0]   pending
);

    state_t      state;
    state_t      state_next;
    logic        supported;
    logic [1:0]  new_cmd;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [33:0] head;
    logic [1:0]  head_cmd;
    logic [31:0] param_q;
    logic [2:0]  idx;

    // Funct decode into the stored command encoding
    always_comb begin
        supported = 1'b1;
        new_cmd   = CMD_CHAR;
        case (syscall_funct)
            SYS_PRINT_CHAR: new_cmd = CMD_CHAR;
            SYS_PRINT_INT:  new_cmd = CMD_INT;
            SYS_EXIT:       new_cmd = CMD_EXIT;
            default:        supported = 1'b0;
        endcase
    end

    // Full blocks enqueue outright, even if the serialiser pops this cycle
    assign push      = syscall_valid && !halted && supported && !full;
    assign stall_req = full;
    assign halted    = (state == ST_HALT);
    assign head_cmd  = head[33:32];

    syscall_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (34)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   ({new_cmd, syscall_param1}),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (pending)
    );

    // Sticky unsupported-funct flag, frozen once halted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            bad_syscall <= 1'b0;
        else if (syscall_valid && !halted && !supported)
            bad_syscall <= 1'b1;
    end

    // Serialiser state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Latch the popped parameter; step the nibble index on each hex transfer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            param_q <= '0;
            idx     <= '0;
        end else if (pop) begin
            param_q <= head[31:0];
            idx     <= 3'd7;
        end else if (state == ST_HEX && out_ready) begin
            idx     <= idx - 3'd1;
        end
    end

    // Next state and byte-port outputs; out_valid comes only from state
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    case (head_cmd)
                        CMD_CHAR: state_next = ST_CHAR;
                        CMD_INT:  state_next = ST_HEX;
                        default:  state_next = ST_HALT;
                    endcase
                end
            end
            ST_CHAR: begin
                out_valid = 1'b1;
                out_data  = param_q[7:0];
                if (out_ready)
                    state_next = ST_IDLE;
            end
            ST_HEX: begin
                out_valid = 1'b1;
                out_data  = hex_ascii(param_q[{idx, 2'b00} +: 4]);
                if (out_ready && idx == 3'd0)
`ifdef SYSCALL_NEWLINE_EN
                    state_next = ST_NL;
`else
                    state_next = ST_IDLE;
`endif
            end
`ifdef SYSCALL_NEWLINE_EN
            ST_NL: begin
                out_valid = 1'b1;
                out_data  = ASCII_NL;
                if (out_ready)
                    state_next = ST_IDLE;
            end
`endif
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_syscall_console.sv
// ============================================================================
//  Module   : tb_syscall_console
//  Brief    : Directed self-checking bench for syscall_console: a table of
//             single-syscall vectors plus hand-written multi-cycle sequences
//             (latency, full queue, exit ordering, sticky flags, mid-reset).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_syscall_console;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
`ifdef SYSCALL_NEWLINE_EN
    localparam int NL_BYTES = 1;
`else
    localparam int NL_BYTES = 0;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             syscall_valid = 1'b0;
    logic [31:0]      syscall_funct = '0;
    logic [31:0]      syscall_param1 = '0;
    logic             stall_req;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready = 1'b0;
    logic             halted;
    logic             bad_syscall;
    logic [PTR_W:0]   pending;

    always #5 clock = ~clock;

    syscall_console #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .syscall_valid  (syscall_valid),
        .syscall_funct  (syscall_funct),
        .syscall_param1 (syscall_param1),
        .stall_req      (stall_req),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .halted         (halted),
        .bad_syscall    (bad_syscall),
        .pending        (pending)
    );

    typedef struct {
        string       name;
        logic [31:0] funct;
        logic [31:0] param;
        int          nbytes;
        logic [71:0] bytes;   // expected bytes, first byte in [71:64]
        logic        bad;
        logic        halt;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] rx[$];
    int         n_vec  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at a negedge with inputs idle
    task automatic apply_reset();
        @(negedge clock);
        syscall_valid = 1'b0;
        out_ready     = 1'b0;
        reset_n       = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Presents one syscall across exactly one rising edge
    task automatic push_one(input logic [31:0] f, input logic [31:0] p);
        @(negedge clock);
        syscall_valid  = 1'b1;
        syscall_funct  = f;
        syscall_param1 = p;
        @(negedge clock);
        syscall_valid  = 1'b0;
    endtask

    // Records every transfer over ncyc cycles, sampling at negedges
    task automatic collect(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (out_valid && out_ready)
                rx.push_back(out_data);
            @(negedge clock);
        end
    endtask

    task automatic chk_rx(input string name, input int nbytes, input logic [71:0] bytes);
        logic [71:0] b;
        b = bytes;
        chk({name, "_count"}, rx.size(), nbytes);
        for (int i = 0; i < nbytes && i < rx.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), {24'd0, rx[i]}, {24'd0, b[71 - 8*i -: 8]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"char_A",     32'd11, 32'h0000_0041, 1,            72'h41_0000000000000000, 1'b0, 1'b0});
        vecs.push_back('{"char_low",   32'd11, 32'h1234_5678, 1,            72'h78_0000000000000000, 1'b0, 1'b0});
        vecs.push_back('{"int_dead",   32'd1,  32'hDEAD_BEEF, 8 + NL_BYTES, 72'h6465616462656566_0a, 1'b0, 1'b0});
        vecs.push_back('{"int_0123",   32'd1,  32'h0123_4567, 8 + NL_BYTES, 72'h3031323334353637_0a, 1'b0, 1'b0});
        vecs.push_back('{"int_89af",   32'd1,  32'h89AB_CDEF, 8 + NL_BYTES, 72'h3839616263646566_0a, 1'b0, 1'b0});
        vecs.push_back('{"int_zero",   32'd1,  32'h0000_0000, 8 + NL_BYTES, 72'h3030303030303030_0a, 1'b0, 1'b0});
        vecs.push_back('{"exit",       32'd10, 32'h0000_0000, 0,            72'h0,                   1'b0, 1'b1});
        vecs.push_back('{"bad4",       32'd4,  32'h0000_0041, 0,            72'h0,                   1'b1, 1'b0});
        vecs.push_back('{"bad0",       32'd0,  32'h0000_0041, 0,            72'h0,                   1'b1, 1'b0});
        vecs.push_back('{"bad12",      32'd12, 32'h0000_0041, 0,            72'h0,                   1'b1, 1'b0});

        // Reset state while reset is held
        #1 reset_n = 1'b0;
        #3;
        chk("rst_stall",   {31'd0, stall_req},   32'd0);
        chk("rst_valid",   {31'd0, out_valid},   32'd0);
        chk("rst_data",    {24'd0, out_data},    32'd0);
        chk("rst_halted",  {31'd0, halted},      32'd0);
        chk("rst_bad",     {31'd0, bad_syscall}, 32'd0);
        chk("rst_pending", {29'd0, pending},     32'd0);

        // Table of single-syscall vectors with out_ready held high
        foreach (vecs[k]) begin
            apply_reset();
            out_ready = 1'b1;
            rx.delete();
            push_one(vecs[k].funct, vecs[k].param);
            collect(30);
            chk_rx(vecs[k].name, vecs[k].nbytes, vecs[k].bytes);
            chk({vecs[k].name, "_pending"}, {29'd0, pending},     32'd0);
            chk({vecs[k].name, "_bad"},     {31'd0, bad_syscall}, {31'd0, vecs[k].bad});
            chk({vecs[k].name, "_halted"},  {31'd0, halted},      {31'd0, vecs[k].halt});
        end

        // Latency: accepted at E0, out_valid after E1, single byte, no newline
        apply_reset();
        out_ready      = 1'b1;
        syscall_valid  = 1'b1;
        syscall_funct  = 32'd11;
        syscall_param1 = 32'h41;
        @(negedge clock);
        syscall_valid = 1'b0;
        chk("lat_e0_valid",   {31'd0, out_valid}, 32'd0);
        chk("lat_e0_pending", {29'd0, pending},   32'd1);
        @(negedge clock);
        chk("lat_e1_valid",   {31'd0, out_valid}, 32'd1);
        chk("lat_e1_data",    {24'd0, out_data},  32'h41);
        chk("lat_e1_pending", {29'd0, pending},   32'd0);
        @(negedge clock);
        chk("lat_e2_valid",   {31'd0, out_valid}, 32'd0);

        // Full queue: one entry held by the serialiser, four in the FIFO
        apply_reset();
        out_ready = 1'b0;
        rx.delete();
        for (int i = 0; i < 5; i++) begin
            syscall_valid  = 1'b1;
            syscall_funct  = 32'd11;
            syscall_param1 = 32'h61 + i;
            @(negedge clock);
        end
        chk("full_stall",   {31'd0, stall_req}, 32'd1);
        chk("full_pending", {29'd0, pending},   32'd4);
        chk("full_data",    {24'd0, out_data},  32'h61);
        chk("full_valid",   {31'd0, out_valid}, 32'd1);
        syscall_param1 = 32'h66;
        repeat (3) @(negedge clock);
        chk("full_hold_pending", {29'd0, pending},   32'd4);
        chk("full_hold_data",    {24'd0, out_data},  32'h61);
        syscall_valid = 1'b0;
        out_ready     = 1'b1;
        collect(20);
        chk_rx("full_drain", 5, 72'h6162636465_00000000);
        chk("full_drain_stall", {31'd0, stall_req}, 32'd0);

        // EXIT waits for earlier output; later entry stays queued forever
        apply_reset();
        out_ready = 1'b1;
        rx.delete();
        fork
            begin
                push_one(32'd1, 32'h0000_0001);
                push_one(32'd10, 32'h0);
                push_one(32'd11, 32'h78);
            end
            collect(40);
        join
        chk_rx("exit_seq", 8 + NL_BYTES, 72'h3030303030303031_0a);
        chk("exit_halted",  {31'd0, halted},  32'd1);
        chk("exit_pending", {29'd0, pending}, 32'd1);
        push_one(32'd11, 32'h79);
        push_one(32'd4,  32'h0);
        rx.delete();
        collect(10);
        chk("exit_after_pending", {29'd0, pending},     32'd1);
        chk("exit_after_bad",     {31'd0, bad_syscall}, 32'd0);
        chk("exit_after_bytes",   rx.size(),            32'd0);

        // Sticky bad flag survives a good syscall, cleared only by reset
        apply_reset();
        out_ready = 1'b1;
        rx.delete();
        push_one(32'd4, 32'h0);
        push_one(32'd11, 32'h6B);
        collect(10);
        chk("bad_sticky",   {31'd0, bad_syscall}, 32'd1);
        chk_rx("bad_then_char", 1, 72'h6B_0000000000000000);
        apply_reset();
        chk("bad_cleared",  {31'd0, bad_syscall}, 32'd0);

        // Reset during the third hex digit abandons the output
        apply_reset();
        out_ready = 1'b1;
        push_one(32'd1, 32'hDEAD_BEEF);
        push_one(32'd11, 32'h71);
        begin : wait_third
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (out_valid && out_data == 8'h61)
                    seen = 1'b1;
                else
                    @(negedge clock);
            end
            chk("mid_third_seen", {31'd0, seen}, 32'd1);
        end
        chk("mid_pre_pending", {29'd0, pending}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_valid",   {31'd0, out_valid}, 32'd0);
        chk("mid_pending", {29'd0, pending},   32'd0);
        chk("mid_halted",  {31'd0, halted},    32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rx.delete();
        push_one(32'd11, 32'h7A);
        collect(10);
        chk_rx("mid_after", 1, 72'h7A_0000000000000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
